// File: rtl/adc128s_spi_model_pkg.sv
// Shared constants, channel map and FSM encodings for the ADC128S SPI model.
package adc128s_spi_model_pkg;

   localparam int FRAME_BITS = 16;
   localparam int DATA_W     = 12;

   localparam logic [2:0] CH_LD_LFT  = 3'd0;
   localparam logic [2:0] CH_LD_RGHT = 3'd4;
   localparam logic [2:0] CH_STEER   = 3'd5;
   localparam logic [2:0] CH_BATT    = 3'd6;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   // Channels without a connected sensor read back as zero.
   function automatic logic [DATA_W-1:0] map_channel(
      input logic [2:0]        ch,
      input logic [DATA_W-1:0] lft,
      input logic [DATA_W-1:0] rght,
      input logic [DATA_W-1:0] steer,
      input logic [DATA_W-1:0] batt
   );
      logic [DATA_W-1:0] val;
      val = '0;
      case (ch)
         CH_LD_LFT:  val = lft;
         CH_LD_RGHT: val = rght;
         CH_STEER:   val = steer;
         CH_BATT:    val = batt;
         default:    val = '0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/adc128s_spi_model_if.sv
// 4-wire SPI bus between the A2D master and the ADC128S model.
interface adc128s_spi_model_if;

   logic SS_n;
   logic SCLK;
   logic MOSI;
   logic MISO;

   modport master (output SS_n, output SCLK, output MOSI, input MISO);
   modport slave  (input SS_n, input SCLK, input MOSI, output MISO);

endinterface

// File: rtl/adc128s_spi_model_spi_edge_sync.sv
// Brings the asynchronous SPI inputs into the clk domain and detects
// SS_n / SCLK edges one flop behind the synchronized value.
module spi_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic SS_n,
   input  logic SCLK,
   input  logic MOSI,
   output logic ss_fall,
   output logic ss_rise,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic mosi_sync
);

   logic [2:0] ss_q;
   logic [2:0] sclk_q;
   logic [1:0] mosi_q;

   // SS_n flops reset to the idle (deselected) level so release of reset
   // never fabricates a frame start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ss_q   <= 3'b111;
         sclk_q <= 3'b000;
         mosi_q <= 2'b00;
      end else begin
         ss_q   <= {ss_q[1:0], SS_n};
         sclk_q <= {sclk_q[1:0], SCLK};
         mosi_q <= {mosi_q[0], MOSI};
      end
   end

   assign ss_fall   = ~ss_q[1] &  ss_q[2];
   assign ss_rise   =  ss_q[1] & ~ss_q[2];
   assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
   assign sclk_fall = ~sclk_q[1] &  sclk_q[2];
   assign mosi_sync =  mosi_q[1];

endmodule

// File: rtl/adc128s_spi_model.sv
// ADC128S-style 8-channel 12-bit SPI A2D model; each frame addresses a
// channel and the following frame returns that channel's sample.
module adc128s_spi_model
   import adc128s_spi_model_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   adc128s_spi_model_if.slave spi,
   input  logic [DATA_W-1:0] ld_cell_lft,
   input  logic [DATA_W-1:0] ld_cell_rght,
   input  logic [DATA_W-1:0] steerPot,
   input  logic [DATA_W-1:0] batt
);

   localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);
   localparam logic [4:0] CNT_MAX   = 5'(FRAME_BITS + 1);

   logic                  ss_fall;
   logic                  ss_rise;
   logic                  sclk_rise;
   logic                  sclk_fall;
   logic                  mosi_sync;

   logic [0:0]            state;
   logic [FRAME_BITS-1:0] tx_shft;
   logic [FRAME_BITS-1:0] rx_shft;
   logic [4:0]            bit_cnt;
   logic [2:0]            chnl;
   logic [DATA_W-1:0]     result;

   spi_edge_sync u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .SS_n      (spi.SS_n),
      .SCLK      (spi.SCLK),
      .MOSI      (spi.MOSI),
      .ss_fall   (ss_fall),
      .ss_rise   (ss_rise),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .mosi_sync (mosi_sync)
   );

   // Only frames of exactly FRAME_BITS rising edges commit a new channel;
   // the count saturates so over-long frames stay distinguishable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         tx_shft <= '0;
         rx_shft <= '0;
         bit_cnt <= '0;
         chnl    <= CH_LD_LFT;
         result  <= '0;
      end else if (state == IDLE) begin
         if (ss_fall) begin
            tx_shft <= {{(FRAME_BITS-DATA_W){1'b0}}, result};
            bit_cnt <= '0;
            state   <= SHIFT;
         end
      end else begin
         if (ss_rise) begin
            state <= IDLE;
            if (bit_cnt == FRAME_CNT) begin
               chnl   <= rx_shft[13:11];
               result <= map_channel(rx_shft[13:11], ld_cell_lft,
                                     ld_cell_rght, steerPot, batt);
            end
         end else begin
            if (sclk_rise) begin
               rx_shft <= {rx_shft[FRAME_BITS-2:0], mosi_sync};
               if (bit_cnt != CNT_MAX)
                  bit_cnt <= bit_cnt + 5'd1;
            end
            // A fall before the first rise (SCLK idling high) must not shift.
            if (sclk_fall && (bit_cnt != 5'd0))
               tx_shft <= {tx_shft[FRAME_BITS-2:0], 1'b0};
         end
      end
   end

   assign spi.MISO = (state == SHIFT) ? tx_shft[FRAME_BITS-1] : 1'b0;

   logic unused_bits;
   assign unused_bits = ^{chnl, rx_shft[15:14], rx_shft[10:0]};

endmodule

// File: tb/tb_adc128s_spi_model.sv
// Directed bench for adc128s_spi_model: a bus-master task issues frames and
// queues expected replies, a separate monitor pops and compares them.
module tb_adc128s_spi_model;
   import adc128s_spi_model_pkg::*;

   logic              clk;
   logic              rst_n;
   logic [DATA_W-1:0] ld_cell_lft;
   logic [DATA_W-1:0] ld_cell_rght;
   logic [DATA_W-1:0] steerPot;
   logic [DATA_W-1:0] batt;

   adc128s_spi_model_if spi_bus ();

   adc128s_spi_model dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .spi          (spi_bus.slave),
      .ld_cell_lft  (ld_cell_lft),
      .ld_cell_rght (ld_cell_rght),
      .steerPot     (steerPot),
      .batt         (batt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] exp_q[$];
   string       name_q[$];
   logic [15:0] obs_word;
   event        obs_ev;
   int          compared   = 0;
   int          mismatched = 0;

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input logic [15:0] got);
      logic [15:0] exp;
      string       nm;
      compared++;
      if (exp_q.size() == 0) begin
         mismatched++;
         $display("[TB] FAIL unexpected_output: got 0x%04h, no expectation queued", got);
      end else begin
         exp = exp_q.pop_front();
         nm  = name_q.pop_front();
         if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", nm, got, exp);
         end
      end
   endtask

   initial begin
      forever begin
         @(obs_ev);
         checkOutput(obs_word);
      end
   end

   task automatic observeMiso(input string nm);
      exp_q.push_back(16'h0000);
      name_q.push_back(nm);
      obs_word = {15'b0, spi_bus.MISO};
      -> obs_ev;
   endtask

   // Mode-0 frame of nbits; MISO is captured on each of the first 16 rises.
   task automatic applyStimulus(input string nm, input logic [15:0] cmd,
                                input int nbits, input logic check,
                                input logic [15:0] exp);
      logic [15:0] word;
      logic [16:0] bits;
      word = '0;
      bits = {cmd, 1'b0};
      if (check) begin
         exp_q.push_back(exp);
         name_q.push_back(nm);
      end
      spi_bus.SS_n = 1'b0;
      waitClk(8);
      for (int i = 0; i < nbits; i++) begin
         spi_bus.MOSI = bits[16-i];
         waitClk(4);
         spi_bus.SCLK = 1'b1;
         if (i < 16) word = {word[14:0], spi_bus.MISO};
         waitClk(8);
         spi_bus.SCLK = 1'b0;
         waitClk(4);
      end
      waitClk(8);
      spi_bus.SS_n = 1'b1;
      waitClk(8);
      if (check) begin
         obs_word = word;
         -> obs_ev;
      end
      waitClk(2);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n        = 1'b0;
      spi_bus.SS_n = 1'b1;
      spi_bus.SCLK = 1'b0;
      spi_bus.MOSI = 1'b0;
      ld_cell_lft  = 12'd330;
      ld_cell_rght = 12'h000;
      steerPot     = 12'h7FF;
      batt         = 12'hFFF;
      waitClk(5);
      observeMiso("reset_miso");
      rst_n = 1'b1;
      waitClk(5);

      applyStimulus("post_reset_frame", 16'h0000, 16, 1'b1, 16'h0000);
      applyStimulus("ch0_ld_lft",       16'h3000, 16, 1'b1, 16'h014A);
      applyStimulus("ch6_batt",         16'h2800, 16, 1'b1, 16'h0FFF);
      applyStimulus("ch5_steer",        16'h1000, 16, 1'b1, 16'h07FF);
      ld_cell_rght = 12'd330;
      applyStimulus("ch2_unmapped",     16'h2000, 16, 1'b1, 16'h0000);

      applyStimulus("short_frame",      16'h3000, 8,  1'b0, 16'h0000);
      observeMiso("idle_after_short");
      applyStimulus("ch4_after_short",  16'h3800, 16, 1'b1, 16'h014A);

      ld_cell_lft = 12'hABC;
      applyStimulus("ch7_unmapped",     16'hC7FF, 16, 1'b1, 16'h0000);
      applyStimulus("long_frame_data",  16'h3000, 17, 1'b1, 16'h0ABC);
      applyStimulus("after_long_frame", 16'h2800, 16, 1'b1, 16'h0ABC);

      // Abort a frame with reset after 7 SCLK edges (4 rises, 3 falls).
      ld_cell_lft  = 12'd330;
      spi_bus.SS_n = 1'b0;
      waitClk(8);
      for (int i = 0; i < 4; i++) begin
         spi_bus.MOSI = 1'b1;
         waitClk(4);
         spi_bus.SCLK = 1'b1;
         waitClk(8);
         if (i < 3) begin
            spi_bus.SCLK = 1'b0;
            waitClk(4);
         end
      end
      rst_n = 1'b0;
      waitClk(2);
      observeMiso("miso_in_mid_reset");
      spi_bus.SS_n = 1'b1;
      spi_bus.SCLK = 1'b0;
      spi_bus.MOSI = 1'b0;
      waitClk(3);
      rst_n = 1'b1;
      waitClk(4);
      observeMiso("miso_after_abort");
      applyStimulus("frame_after_abort", 16'h0000, 16, 1'b1, 16'h0000);
      applyStimulus("ch0_after_abort",   16'h0000, 16, 1'b1, 16'h014A);

      waitClk(20);
      if (exp_q.size() != 0) begin
         $display("[TB] FAIL pending_expectations: got %0d left, expected 0", exp_q.size());
         mismatched += exp_q.size();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
